// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode/operand word pairs, buffers them in a small FIFO and
// presents them on a valid/ready handshake. Supports redirect (jump) and halt on HALT_OP.
module fetch_unit #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 100,
    parameter logic [7:0]  HALT_OP  = 8'hff
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [7:0]       ins_opcode,
    output logic [WIDTH-1:0] ins_operand,
    output logic [WIDTH-1:0] ins_pc,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    output logic             halted
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StOp, StArg, StHalt} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    reserved_q, reserved_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             resp_vld_q, resp_vld_d;
    logic             resp_arg_q, resp_arg_d;
    logic [WIDTH-1:0] resp_addr_q, resp_addr_d;
    logic [7:0]       asm_op_q, asm_op_d;
    logic [WIDTH-1:0] asm_pc_q, asm_pc_d;

    logic [7:0]       fifo_op_q  [DEPTH];
    logic [WIDTH-1:0] fifo_arg_q [DEPTH];
    logic [WIDTH-1:0] fifo_pc_q  [DEPTH];

    logic             push, pop, issue_op, resp_op, req_int;
    logic [CW:0]      occupancy;

    always_comb begin
        resp_op   = resp_vld_q & ~resp_arg_q;
        push      = resp_vld_q & resp_arg_q & ~jump_en;
        ins_valid = ~reset & (count_q != '0);
        pop       = ins_valid & ins_ready;
        // Pairs already requested count against capacity so a push can never overflow.
        occupancy = {1'b0, count_q} + {1'b0, reserved_q};

        req_int    = 1'b0;
        issue_op   = 1'b0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;

        case (state_q)
            StOp: begin
                if (32'(occupancy) < DEPTH) begin
                    req_int    = 1'b1;
                    issue_op   = 1'b1;
                    fetch_pc_d = fetch_pc_q + WIDTH'(1);
                    state_d    = StArg;
                end
            end
            StArg: begin
                req_int    = 1'b1;
                fetch_pc_d = fetch_pc_q + WIDTH'(1);
                state_d    = (resp_op && mem_rdata[7:0] == HALT_OP) ? StHalt : StOp;
            end
            StHalt: ;
            default: state_d = StOp;
        endcase

        reserved_d = reserved_q + CW'(issue_op) - CW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        asm_op_d   = resp_op ? mem_rdata[7:0] : asm_op_q;
        asm_pc_d   = resp_op ? resp_addr_q : asm_pc_q;
        mem_req    = req_int;

        if (jump_en) begin
            mem_req    = 1'b0;
            state_d    = StOp;
            fetch_pc_d = jump_target;
            reserved_d = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            asm_op_d   = '0;
            asm_pc_d   = '0;
        end
        if (reset) begin
            mem_req = 1'b0;
        end

        mem_addr    = mem_req ? fetch_pc_q : '0;
        resp_vld_d  = mem_req;
        resp_arg_d  = (state_q == StArg);
        resp_addr_d = fetch_pc_q;

        halted      = ~reset & (state_q == StHalt);
        ins_opcode  = ins_valid ? fifo_op_q[rd_ptr_q]  : '0;
        ins_operand = ins_valid ? fifo_arg_q[rd_ptr_q] : '0;
        ins_pc      = ins_valid ? fifo_pc_q[rd_ptr_q]  : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StOp;
            fetch_pc_q  <= WIDTH'(RESET_PC);
            count_q     <= '0;
            reserved_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            resp_vld_q  <= 1'b0;
            resp_arg_q  <= 1'b0;
            resp_addr_q <= '0;
            asm_op_q    <= '0;
            asm_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            reserved_q  <= reserved_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            resp_vld_q  <= resp_vld_d;
            resp_arg_q  <= resp_arg_d;
            resp_addr_q <= resp_addr_d;
            asm_op_q    <= asm_op_d;
            asm_pc_q    <= asm_pc_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q]  <= asm_op_q;
            fifo_arg_q[wr_ptr_q] <= mem_rdata;
            fifo_pc_q[wr_ptr_q]  <= asm_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: program-order model of reads and deliveries plus
// directed literal checks for latency, back-pressure, jump, halt, wrap and mid-run reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'hbeef;
    logic        ins_valid;
    logic        ins_ready;
    logic [7:0]  ins_opcode;
    logic [15:0] ins_operand;
    logic [15:0] ins_pc;
    logic        jump_en;
    logic [15:0] jump_target;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] ov [int];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_opcode (ins_opcode),
        .ins_operand(ins_operand),
        .ins_pc     (ins_pc),
        .jump_en    (jump_en),
        .jump_target(jump_target),
        .halted     (halted)
    );

    // Default memory content never has an 8'hff low byte, so only explicit overrides halt.
    function automatic logic [15:0] memf(input logic [15:0] a);
        if (ov.exists(int'(a))) return ov[int'(a)];
        return {a[7:0], 1'b0, a[6:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One-cycle-latency memory
    always @(posedge clk) mem_rdata <= mem_req ? memf(mem_addr) : 16'hbeef;

    // Model: reads walk the program sequentially from the last reset/jump target until the
    // operand read of a HALT pair; deliveries walk the same sequence two words at a time.
    logic [15:0] m_rd_addr, m_dl_pc, w_tmp;
    bit          m_phase, m_pend, m_stop, m_expect_empty;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_ins_valid", 32'(ins_valid), 32'd0);
            chk("rst_ins_opcode", 32'(ins_opcode), 32'd0);
            chk("rst_ins_operand", 32'(ins_operand), 32'd0);
            chk("rst_ins_pc", 32'(ins_pc), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            m_rd_addr      = 16'd100;
            m_dl_pc        = 16'd100;
            m_phase        = 1'b0;
            m_pend         = 1'b0;
            m_stop         = 1'b0;
            m_expect_empty = 1'b0;
        end else begin
            if (m_expect_empty) chk("valid_after_jump", 32'(ins_valid), 32'd0);
            m_expect_empty = 1'b0;
            chk("halted", 32'(halted), 32'(m_stop));
            if (ins_valid && ins_ready) begin
                w_tmp = memf(m_dl_pc);
                chk("ins_pc", 32'(ins_pc), 32'(m_dl_pc));
                chk("ins_opcode", 32'(ins_opcode), 32'(w_tmp[7:0]));
                chk("ins_operand", 32'(ins_operand), 32'(memf(m_dl_pc + 16'd1)));
                m_dl_pc = m_dl_pc + 16'd2;
            end
            if (jump_en) begin
                chk("req_in_jump", 32'(mem_req), 32'd0);
                m_rd_addr      = jump_target;
                m_dl_pc        = jump_target;
                m_phase        = 1'b0;
                m_pend         = 1'b0;
                m_stop         = 1'b0;
                m_expect_empty = 1'b1;
            end else if (mem_req) begin
                if (m_stop) begin
                    chk("req_after_halt", 32'(mem_req), 32'd0);
                end else begin
                    chk("rd_addr", 32'(mem_addr), 32'(m_rd_addr));
                    if (!m_phase) begin
                        w_tmp  = memf(m_rd_addr);
                        m_pend = (w_tmp[7:0] == 8'hff);
                        m_phase = 1'b1;
                    end else begin
                        m_phase = 1'b0;
                        if (m_pend) m_stop = 1'b1;
                    end
                    m_rd_addr = m_rd_addr + 16'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int          nreq;
    logic [15:0] last_addr;
    bit          seen_halt;
    logic [15:0] halt_operand;

    initial begin
        reset       = 1'b1;
        ins_ready   = 1'b1;
        jump_en     = 1'b0;
        jump_target = 16'd0;
        ov[100]     = 16'h1241;
        ov[101]     = 16'd13;

        // 1: first instruction latency
        do_reset();
        @(negedge clk);
        chk("t1_req0", 32'(mem_req), 32'd1);
        chk("t1_addr0", 32'(mem_addr), 32'd100);
        @(negedge clk);
        chk("t1_addr1", 32'(mem_addr), 32'd101);
        @(negedge clk);
        chk("t1_valid_c2", 32'(ins_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_c3", 32'(ins_valid), 32'd1);
        chk("t1_opcode", 32'(ins_opcode), 32'h41);
        chk("t1_operand", 32'(ins_operand), 32'd13);
        chk("t1_pc", 32'(ins_pc), 32'd100);

        // 2: back-pressure fills the FIFO, then drain
        tick();
        ins_ready = 1'b0;
        do_reset();
        nreq = 0;
        last_addr = 16'd0;
        repeat (30) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                last_addr = mem_addr;
            end
        end
        chk("t2_nreq", 32'(nreq), 32'd8);
        chk("t2_last_addr", 32'(last_addr), 32'd107);
        chk("t2_stalled", 32'(mem_req), 32'd0);
        chk("t2_head_valid", 32'(ins_valid), 32'd1);
        chk("t2_head_pc", 32'(ins_pc), 32'd100);
        tick();
        ins_ready = 1'b1;
        repeat (30) tick();

        // 3: jump with three entries buffered
        ins_ready = 1'b0;
        do_reset();
        repeat (7) tick();
        jump_en     = 1'b1;
        jump_target = 16'd200;
        tick();
        jump_en   = 1'b0;
        ins_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid", 32'(ins_valid), 32'd0);
        chk("t3_req", 32'(mem_req), 32'd1);
        chk("t3_addr", 32'(mem_addr), 32'd200);
        repeat (3) @(negedge clk);
        chk("t3_valid_c3", 32'(ins_valid), 32'd1);
        chk("t3_pc", 32'(ins_pc), 32'd200);
        repeat (20) tick();

        // 4: halt pair at 104/105
        ov[104] = 16'h00ff;
        ov[105] = 16'd4;
        do_reset();
        nreq = 0;
        seen_halt = 1'b0;
        halt_operand = 16'd0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                last_addr = mem_addr;
            end
            if (ins_valid && ins_ready && ins_opcode == 8'hff) begin
                seen_halt = 1'b1;
                halt_operand = ins_operand;
            end
        end
        chk("t4_nreq", 32'(nreq), 32'd6);
        chk("t4_last_addr", 32'(last_addr), 32'd105);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_seen_halt", 32'(seen_halt), 32'd1);
        chk("t4_halt_operand", 32'(halt_operand), 32'd4);
        tick();
        jump_en     = 1'b1;
        jump_target = 16'd100;
        tick();
        jump_en = 1'b0;
        @(negedge clk);
        chk("t4_unhalted", 32'(halted), 32'd0);
        chk("t4_restart_addr", 32'(mem_addr), 32'd100);
        repeat (12) tick();

        // 5: pair straddling the address wrap
        jump_en     = 1'b1;
        jump_target = 16'hffff;
        tick();
        jump_en = 1'b0;
        @(negedge clk);
        chk("t5_addr_ffff", 32'(mem_addr), 32'hffff);
        @(negedge clk);
        chk("t5_addr_0000", 32'(mem_addr), 32'h0000);
        chk("t5_req_0000", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("t5_addr_0001", 32'(mem_addr), 32'h0001);
        @(negedge clk);
        chk("t5_valid", 32'(ins_valid), 32'd1);
        chk("t5_pc", 32'(ins_pc), 32'hffff);
        chk("t5_opcode", 32'(ins_opcode), 32'h7f);
        chk("t5_operand", 32'(ins_operand), 32'h0000);
        repeat (10) tick();

        // 6: reset during the operand-request cycle
        do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_req", 32'(mem_req), 32'd1);
        chk("t6_addr", 32'(mem_addr), 32'd100);
        @(negedge clk);
        @(negedge clk);
        chk("t6_valid_c2", 32'(ins_valid), 32'd0);
        @(negedge clk);
        chk("t6_valid_c3", 32'(ins_valid), 32'd1);
        chk("t6_pc", 32'(ins_pc), 32'd100);
        chk("t6_opcode", 32'(ins_opcode), 32'h41);
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
